// File: rtl/arbitro_display_7segmentos.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arbitro_display_7segmentos
//
// Round-robin arbiter that shares the four-digit 7-segment display between two
// clients. An owner keeps the display for a minimum time before a waiting
// client may take it over. A release is always honoured immediately. The
// arbiter remembers which client it served last and uses that to break ties.
//
// Ports
//   i_Reloj             system clock (rising edge)
//   i_Reset             asynchronous reset, active low
//   i_Req_0 / i_Req_1   level requests from client 0 / client 1
//   i_Datos_Cliente_0/1 client digit buses ([3:0] = digit 0 ... [15:12] = digit 3)
//   o_Grant_0 / 1       registered one-hot (or zero) ownership grants
//   o_Ocupado           some client owns the display
//   o_Datos_0..3        registered digits for the display controller
// -----------------------------------------------------------------------------
module arbitro_display_7segmentos #(
  parameter int unsigned P_CICLOS_MIN = 50_000_000,
  parameter int unsigned P_ANCHO_CONT = $clog2(P_CICLOS_MIN + 1)
) (
  input  logic        i_Reloj,
  input  logic        i_Reset,
  input  logic        i_Req_0,
  input  logic        i_Req_1,
  input  logic [15:0] i_Datos_Cliente_0,
  input  logic [15:0] i_Datos_Cliente_1,
  output logic        o_Grant_0,
  output logic        o_Grant_1,
  output logic        o_Ocupado,
  output logic [3:0]  o_Datos_0,
  output logic [3:0]  o_Datos_1,
  output logic [3:0]  o_Datos_2,
  output logic [3:0]  o_Datos_3
);

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    CLIENTE_0 = 2'd1,
    CLIENTE_1 = 2'd2
  } estado_t;

  localparam logic [P_ANCHO_CONT-1:0] CONT_MAX = P_ANCHO_CONT'(P_CICLOS_MIN);

  estado_t                 estado;
  estado_t                 estado_sig;
  logic [P_ANCHO_CONT-1:0] cont;
  logic                    cont_lleno;
  logic                    ultimo;
  logic [15:0]             datos;

  // The minimum ownership time has elapsed; a waiting client may preempt.
  assign cont_lleno = (cont == CONT_MAX);

  // Next-state decision. Registered outputs are derived from estado_sig so the
  // grant and the new owner's data appear on the same edge that samples the
  // request.
  always_comb begin
    // NOTE: default assignment first so no path leaves estado_sig unassigned
    // (an unassigned path would infer a latch).
    estado_sig = estado;
    case (estado)
      LIBRE: begin
        if (i_Req_0 && i_Req_1)
          estado_sig = ultimo ? CLIENTE_0 : CLIENTE_1;
        else if (i_Req_0)
          estado_sig = CLIENTE_0;
        else if (i_Req_1)
          estado_sig = CLIENTE_1;
      end
      CLIENTE_0: begin
        if (!i_Req_0)
          estado_sig = i_Req_1 ? CLIENTE_1 : LIBRE;
        else if (i_Req_1 && cont_lleno)
          estado_sig = CLIENTE_1;
      end
      CLIENTE_1: begin
        if (!i_Req_1)
          estado_sig = i_Req_0 ? CLIENTE_0 : LIBRE;
        else if (i_Req_0 && cont_lleno)
          estado_sig = CLIENTE_0;
      end
      default: estado_sig = LIBRE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      estado    <= LIBRE;
      o_Grant_0 <= 1'b0;
      o_Grant_1 <= 1'b0;
      o_Ocupado <= 1'b0;
      cont      <= '0;
      ultimo    <= 1'b1;   // client 0 wins the first tie
      // NOTE: the display register is reset as well: the display has to show
      // zeros after reset, not whatever was shown before it.
      datos     <= 16'h0000;
    end else begin
      estado    <= estado_sig;
      o_Grant_0 <= (estado_sig == CLIENTE_0);
      o_Grant_1 <= (estado_sig == CLIENTE_1);
      o_Ocupado <= (estado_sig != LIBRE);

      // The ownership counter restarts on every entry, including a direct
      // handover, counts while owned, saturates, and stays at 0 when idle.
      if (estado_sig == LIBRE) begin
        cont <= '0;
      end else if (estado_sig != estado) begin
        cont   <= '0;
        ultimo <= (estado_sig == CLIENTE_1);
      end else if (!cont_lleno) begin
        cont <= cont + P_ANCHO_CONT'(1);
      end

      // When idle, the last digits stay on the display.
      if (estado_sig == CLIENTE_0)
        datos <= i_Datos_Cliente_0;
      else if (estado_sig == CLIENTE_1)
        datos <= i_Datos_Cliente_1;
    end
  end

  assign o_Datos_0 = datos[3:0];
  assign o_Datos_1 = datos[7:4];
  assign o_Datos_2 = datos[11:8];
  assign o_Datos_3 = datos[15:12];

endmodule

// File: tb/tb_arbitro_display_7segmentos.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_arbitro_display_7segmentos
//
// Self-checking bench for the display arbiter with P_CICLOS_MIN = 4 and a
// 2 ns clock. A table of single-cycle vectors covers basic ownership, data
// tracking, idle hold and early release. Hand-written sequences cover reset
// with active requests, tie-break plus periodic preemption, and an
// asynchronous reset in the middle of an ownership.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_arbitro_display_7segmentos;

  localparam int unsigned CICLOS_MIN = 4;

  logic        clk;
  logic        rst_n;
  logic        req_0;
  logic        req_1;
  logic [15:0] datos_c0;
  logic [15:0] datos_c1;
  logic        grant_0;
  logic        grant_1;
  logic        ocupado;
  logic [3:0]  datos_0;
  logic [3:0]  datos_1;
  logic [3:0]  datos_2;
  logic [3:0]  datos_3;

  int n_checks = 0;
  int n_errors = 0;

  arbitro_display_7segmentos #(
    .P_CICLOS_MIN(CICLOS_MIN)
  ) dut (
    .i_Reloj          (clk),
    .i_Reset          (rst_n),
    .i_Req_0          (req_0),
    .i_Req_1          (req_1),
    .i_Datos_Cliente_0(datos_c0),
    .i_Datos_Cliente_1(datos_c1),
    .o_Grant_0        (grant_0),
    .o_Grant_1        (grant_1),
    .o_Ocupado        (ocupado),
    .o_Datos_0        (datos_0),
    .o_Datos_1        (datos_1),
    .o_Datos_2        (datos_2),
    .o_Datos_3        (datos_3)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    logic        req_0;
    logic        req_1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        exp_g0;
    logic        exp_g1;
    logic        exp_ocup;
    logic [15:0] exp_datos;
  } vector_t;

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic g0, input logic g1,
                               input logic ocup, input logic [15:0] datos);
    check({tag, " grant_0"}, 16'(grant_0), 16'(g0));
    check({tag, " grant_1"}, 16'(grant_1), 16'(g1));
    check({tag, " ocupado"}, 16'(ocupado), 16'(ocup));
    check({tag, " datos"}, {datos_3, datos_2, datos_1, datos_0}, datos);
  endtask

  // One clock: drive at the falling edge beforehand, sample at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Grants must never be high together.
  always @(negedge clk) begin
    if (rst_n && grant_0 && grant_1) begin
      n_errors++;
      $display("FAIL grant one-hot: both grants high (t=%0t)", $time);
    end
  end

  vector_t vec [11];

  initial begin
    // Vectors start from the reset state (LIBRE, ultimo = 1, digits 0).
    //             r0    r1    d0        d1        g0    g1    ocup  datos
    vec[0]  = '{1'b0, 1'b0, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}; // idle
    vec[1]  = '{1'b1, 1'b0, 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4321}; // grant 0
    vec[2]  = '{1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0009}; // data tracks
    vec[3]  = '{1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hABCD};
    vec[4]  = '{1'b0, 1'b0, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hABCD}; // release, hold
    vec[5]  = '{1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'hABCD}; // still hold
    vec[6]  = '{1'b0, 1'b1, 16'h1111, 16'h5678, 1'b0, 1'b1, 1'b1, 16'h5678}; // grant 1
    vec[7]  = '{1'b1, 1'b1, 16'h1111, 16'h5678, 1'b0, 1'b1, 1'b1, 16'h5678}; // no preempt yet
    vec[8]  = '{1'b1, 1'b0, 16'h1111, 16'h5678, 1'b1, 1'b0, 1'b1, 16'h1111}; // early release
    vec[9]  = '{1'b1, 1'b1, 16'h2468, 16'h1357, 1'b1, 1'b0, 1'b1, 16'h2468};
    vec[10] = '{1'b0, 1'b1, 16'h2468, 16'h1357, 1'b0, 1'b1, 1'b1, 16'h1357}; // drop + other

    // Reset with both clients requesting: outputs stay at reset values.
    rst_n    = 1'b0;
    req_0    = 1'b1;
    req_1    = 1'b1;
    datos_c0 = 16'hFFFF;
    datos_c1 = 16'hEEEE;
    step();
    step();
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    req_0 = 1'b0;
    req_1 = 1'b0;
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      req_0    = vec[i].req_0;
      req_1    = vec[i].req_1;
      datos_c0 = vec[i].d0;
      datos_c1 = vec[i].d1;
      step();
      check_outputs($sformatf("vec%0d", i), vec[i].exp_g0, vec[i].exp_g1,
                    vec[i].exp_ocup, vec[i].exp_datos);
    end

    // Tie after reset: client 0 wins, then ownership alternates every
    // CICLOS_MIN + 1 edges while both keep requesting.
    rst_n = 1'b0;
    step();
    check_outputs("tie reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n    = 1'b1;
    req_0    = 1'b1;
    req_1    = 1'b1;
    datos_c0 = 16'hAAAA;
    datos_c1 = 16'hBBBB;
    step();
    check_outputs("tie grant", 1'b1, 1'b0, 1'b1, 16'hAAAA);
    for (int k = 1; k <= 10; k++) begin
      logic owner;
      owner = ((k / (CICLOS_MIN + 1)) % 2) == 1;
      step();
      check_outputs($sformatf("tie edge%0d", k), !owner, owner, 1'b1,
                    owner ? 16'hBBBB : 16'hAAAA);
    end

    // Asynchronous reset while client 1 owns the display.
    req_0    = 1'b0;
    req_1    = 1'b0;
    step();
    check_outputs("idle before midreset", 1'b0, 1'b0, 1'b0, 16'hAAAA);
    req_1    = 1'b1;
    datos_c1 = 16'h9876;
    step();
    check_outputs("midreset own1", 1'b0, 1'b1, 1'b1, 16'h9876);
    step();
    check_outputs("midreset own1 hold", 1'b0, 1'b1, 1'b1, 16'h9876);
    #0.4 rst_n = 1'b0;
    #0.2 check_outputs("midreset async", 1'b0, 1'b0, 1'b0, 16'h0000);
    #0.2;
    rst_n = 1'b1;
    req_0 = 1'b1;
    datos_c0 = 16'h0C0C;
    @(negedge clk);
    check_outputs("after reset tie", 1'b1, 1'b0, 1'b1, 16'h0C0C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbitro_display_7segmentos.md
# arbitro_display_7segmentos

Arbiter that shares the Basys 3 four-digit 7-segment display between two data sources. It sits directly upstream of `Controlador_display_7segmentos` and drives its `i_Datos_0..3` inputs. Arbitration is round-robin with a guaranteed minimum ownership time, so the digits never flicker between sources faster than a human can read them. Each client gets a request/grant handshake; the arbiter latches which client was served last.

## Interface

Parameters:
- `P_CICLOS_MIN`, default 50_000_000: minimum ownership time in clock cycles before a waiting client may preempt the owner (0.5 s at 100 MHz). Legal range is ≥ 1.
- `P_ANCHO_CONT`, default `$clog2(P_CICLOS_MIN+1)`: ownership counter width.

Ports:
- `i_Reloj`, in, 1: system clock; all logic on the rising edge.
- `i_Reset`, in, 1: reset, asynchronous and active-low; 0 resets the block.
- `i_Req_0`, in, 1: client 0 requests the display (level, held while it wants ownership).
- `i_Req_1`, in, 1: client 1 request.
- `i_Datos_Cliente_0`, in, 16: client 0 digits; [3:0] is digit 0 … [15:12] is digit 3.
- `i_Datos_Cliente_1`, in, 16: client 1 digits, same packing.
- `o_Grant_0`, out, 1: client 0 owns the display.
- `o_Grant_1`, out, 1: client 1 owns the display.
- `o_Ocupado`, out, 1: some client owns the display (`o_Grant_0 | o_Grant_1`).
- `o_Datos_0` … `o_Datos_3`, out, 4 each: digits to the display controller.

## Operation

- **FSM states:** LIBRE, CLIENTE_0, CLIENTE_1. All outputs are registered.
- **Reset values:**
  - state is LIBRE;
  - both grants and `o_Ocupado` are 0;
  - all `o_Datos_*` are 4'd0;
  - ownership counter is 0;
  - `ultimo` (last client served) is 1, so client 0 wins the first tie.
- **From LIBRE:**
  - only `i_Req_0` high → CLIENTE_0;
  - only `i_Req_1` high → CLIENTE_1;
  - both high → the client ≠ `ultimo`;
  - none high → stay in LIBRE.
- **In CLIENTE_x:**
  - owner request drops → go to CLIENTE_other if the other client requests, else LIBRE. This happens immediately, regardless of the counter.
  - owner still requesting, other requesting, counter = `P_CICLOS_MIN` → CLIENTE_other (preemption).
  - otherwise stay.
- **Ownership counter:**
  - cleared to 0 on every entry into a CLIENTE state, including a direct CLIENTE_0↔CLIENTE_1 handover;
  - increments each cycle in a CLIENTE state;
  - saturates at `P_CICLOS_MIN`;
  - holds 0 in LIBRE.
- **`ultimo`:** updated to x on every entry into CLIENTE_x.
- **Data path:**
  - `o_Datos_*` are loaded each cycle from the bus of the next-state owner.
  - In LIBRE, `o_Datos_*` hold the last value shown, so the display does not blank between owners.
- **Grant rule:** grants are one-hot or zero; both high at once is forbidden.

## Timing

- **Request to grant:** a request sampled high at edge N raises the grant at edge N (visible after N), provided the arbiter is free or handing over.
- **Data alignment:** `o_Datos_*` change on the same edge as the grant, with the new owner's bus sampled at that edge. While owned, data has 1-cycle latency from the owner bus.
- **Release:** a request drop sampled at edge N clears the grant at edge N.
- **Handover:** release and grant happen in a single edge, with no LIBRE cycle in between.
- **Preemption time:** preemption occurs no earlier than `P_CICLOS_MIN + 1` edges after the grant edge (the counter needs `P_CICLOS_MIN` increments).
- **`P_CICLOS_MIN = 1`:** the owner keeps the display for 2 cycles under contention.
- **Simultaneous events:** when the owner drops and the other requests on the same edge, the handover is immediate and `ultimo` is updated.
- **Reset mid-ownership:** asserting `i_Reset` low forces the reset values asynchronously, without waiting for a clock edge. The first grant after reset goes to client 0 on a tie.
- **Non-requesting client:** a client whose request is low is never granted.

## Test plan

All scenarios use `P_CICLOS_MIN = 4` and a clock period of 2 ns.

1. **Reset:** `i_Reset = 0` for 2 cycles → grants 0, `o_Ocupado` 0, `o_Datos_*` 0, regardless of requests.
2. **Single client:**
   - Stimulus: `i_Req_0 = 1` with `i_Datos_Cliente_0 = 16'h4321`.
   - After the next edge: `o_Grant_0 = 1`, `o_Datos_0..3 = 1,2,3,4`.
   - Change the bus to 16'h0009 → `o_Datos_0 = 9` one edge later.
3. **Tie after reset:**
   - Stimulus: both requests rise together.
   - After the grant edge: `o_Grant_0` is high.
   - Counting from the grant edge, `o_Grant_1` rises exactly at the 5th edge (when the counter reaches 4), and `o_Grant_0` falls on that same edge.
   - With both requests held, ownership keeps alternating every 5 cycles.
4. **Early release:**
   - Client 1 owns the display, and `i_Req_1` drops 1 cycle after the grant while `i_Req_0 = 1`.
   - Required: `o_Grant_0` high on the next edge (no minimum wait) and no cycle with `o_Ocupado = 0`.
5. **Idle hold:**
   - Owner 0 showing 16'hABCD releases with no other request.
   - Required: `o_Ocupado = 0` and `o_Datos_*` still D,C,B,A until a new grant.
6. **Mid-ownership reset:**
   - Pulse `i_Reset` low between clock edges while client 1 owns the display.
   - Required: outputs reach their reset values before the next edge.
   - After release, with both requesting: client 0 is granted first.
